uart_rx: RTL and testbench

- UART receiver: the downstream counterpart of the team's uart_tx on the serial link.
- Oversamples the asynchronous rx line using a 16x baud tick and validates the start bit at mid-bit.
- Shifts in DATAWIDTH bits LSB-first, optionally checks parity, and checks the stop bit.
- Presents each received word through a one-entry valid/ready holding register to the consumer (host or RX FIFO).

---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start validation, LSB-first data, optional parity,
// stop check, and a one-entry valid/ready holding register toward the consumer.
module uart_rx #(
  parameter int DATAWIDTH  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATAWIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy,
  output logic [2:0]           o_dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATAWIDTH + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATAWIDTH - 1);
  localparam logic          ODD_SEL   = (PARITY_ODD != 0);
  localparam logic          PAR_SEL   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_sync1, r_sync2;
  logic [TW-1:0]          r_tick_cnt, w_tick_nxt;
  logic [BW-1:0]          r_bit_cnt, w_bit_nxt;
  logic [DATAWIDTH-1:0]   r_shift, w_shift_nxt;
  logic                   r_perr, w_perr_nxt;
  logic [DATAWIDTH-1:0]   r_data;
  logic                   r_valid, r_ferr, r_perr_out, r_overrun;
  logic                   w_rx_s, w_sample, w_complete, w_ferr;

  assign w_rx_s   = r_sync2;
  assign w_sample = baud_tick && (r_tick_cnt == TICK_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_complete  = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (baud_tick && !w_rx_s) begin
          w_state_nxt = START;
          w_tick_nxt  = '0;
          w_perr_nxt  = 1'b0;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (baud_tick) begin
          if (r_tick_cnt == TICK_MID) begin
            w_tick_nxt = '0;
            w_bit_nxt  = '0;
            w_state_nxt = w_rx_s ? IDLE : DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (w_sample) begin
          w_shift_nxt = {w_rx_s, r_shift[DATAWIDTH-1:1]};
          w_tick_nxt  = '0;
          w_bit_nxt   = r_bit_cnt + BW'(1);
          if (r_bit_cnt == BIT_LAST) w_state_nxt = PAR_SEL ? PARITY : STOP;
        end else if (baud_tick) begin
          w_tick_nxt = r_tick_cnt + TW'(1);
        end
      end
      PARITY: begin
        if (w_sample) begin
          w_perr_nxt  = ((^r_shift) ^ w_rx_s) != ODD_SEL;
          w_tick_nxt  = '0;
          w_state_nxt = STOP;
        end else if (baud_tick) begin
          w_tick_nxt = r_tick_cnt + TW'(1);
        end
      end
      STOP: begin
        // A low stop bit may be a break; wait for the line to go idle.
        if (w_sample) begin
          w_complete  = 1'b1;
          w_ferr      = ~w_rx_s;
          w_tick_nxt  = '0;
          w_state_nxt = w_rx_s ? IDLE : BREAK_WAIT;
        end else if (baud_tick) begin
          w_tick_nxt = r_tick_cnt + TW'(1);
        end
      end
      BREAK_WAIT: begin
        if (baud_tick && w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding register handshake: a word transfers on any clk where rx_valid && rx_ready;
  // rx_data and flags stay stable while rx_valid is high and not accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr_out <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_perr     <= w_perr_nxt;
      r_overrun  <= 1'b0;
      if (w_complete) begin
        if (!r_valid || rx_ready) begin
          r_data     <= r_shift;
          r_ferr     <= w_ferr;
          r_perr_out <= PAR_SEL ? r_perr : 1'b0;
          r_valid    <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_frame_err  = r_ferr;
  assign rx_parity_err = r_perr_out;
  assign rx_overrun    = r_overrun;
  assign rx_busy       = (r_state != IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one plain instance and one even-parity instance,
// baud_tick every 4 clk, 64 clk per bit, scoreboard of accepted words.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int W  = DW + 2;
  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, baud_tick, rx_a, rx_b, rdy_a, rdy_b;
  logic [DW-1:0] data_a, data_b;
  logic v_a, ferr_a, perr_a, ovr_a, busy_a;
  logic v_b, ferr_b, perr_b, ovr_b, busy_b;
  logic [2:0] st_a, st_b;

  uart_rx #(.DATAWIDTH(DW), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx_a), .rx_ready(rdy_a),
    .rx_data(data_a), .rx_valid(v_a), .rx_frame_err(ferr_a), .rx_parity_err(perr_a),
    .rx_overrun(ovr_a), .rx_busy(busy_a), .o_dbg_state(st_a));

  uart_rx #(.DATAWIDTH(DW), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx_b), .rx_ready(rdy_b),
    .rx_data(data_b), .rx_valid(v_b), .rx_frame_err(ferr_b), .rx_parity_err(perr_b),
    .rx_overrun(ovr_b), .rx_busy(busy_b), .o_dbg_state(st_b));

  // clock / tick generation
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = (cyc[1:0] == 2'd0);
    end
  end

  // scoreboard
  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qp[$];
  int acc_a = 0, acc_b = 0, vcyc_a = 0, ovr_cnt_a = 0;
  bit busy_seen_a = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin : mon_a
    logic [W-1:0] got, exp;
    forever begin
      @(negedge clk);
      #1;
      if (v_a === 1'b1) vcyc_a++;
      if (busy_a === 1'b1) busy_seen_a = 1;
      if (ovr_a === 1'b1) ovr_cnt_a++;
      if (v_a === 1'b1 && rdy_a === 1'b1) begin
        got = {perr_a, ferr_a, data_a};
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = ~got;
        acc_a++;
        check_eq("accept_a", 32'(got), 32'(exp));
      end
    end
  end

  initial begin : mon_b
    logic [W-1:0] got, exp;
    forever begin
      @(negedge clk);
      #1;
      if (v_b === 1'b1 && rdy_b === 1'b1) begin
        got = {perr_b, ferr_b, data_b};
        if (exp_qp.size() > 0) exp = exp_qp.pop_front();
        else exp = ~got;
        acc_b++;
        check_eq("accept_b", 32'(got), 32'(exp));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int rdy_at, input int rst_at);
    if (sel) rx_b = v;
    else rx_a = v;
    for (int i = 0; i < BIT_CLK; i++) begin
      if (i == rdy_at) rdy_a = 1'b1;
      if (rdy_at >= 0 && i == rdy_at + 1) rdy_a = 1'b0;
      if (i == rst_at) reset_n = 1'b0;
      if (rst_at >= 0 && i == rst_at + 1) reset_n = 1'b1;
      @(negedge clk);
    end
  endtask

  // Frame starts on a negedge right before a tick, so the stop sample lands 612 negedges in.
  task automatic send_frame(input bit sel, input logic [DW-1:0] d, input logic par_bit,
                            input logic stop, input int rdy_at, input int rst_bit);
    @(negedge clk);
    while (cyc[1:0] != 2'd0) @(negedge clk);
    drive_bit(sel, 1'b0, -1, -1);
    for (int k = 0; k < DW; k++) drive_bit(sel, d[k], -1, (k == rst_bit) ? 10 : -1);
    if (sel) drive_bit(sel, par_bit, -1, -1);
    drive_bit(sel, stop, rdy_at, -1);
  endtask

  initial begin : main
    int a0, v0, o0, b0;
    reset_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    idle(3);
    check_eq("rst_valid", v_a, 0);
    check_eq("rst_data", data_a, 0);
    check_eq("rst_ferr", ferr_a, 0);
    check_eq("rst_perr", perr_a, 0);
    check_eq("rst_overrun", ovr_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_state", st_a, 0);
    check_eq("rst_valid_b", v_b, 0);
    reset_n = 1'b1;
    idle(10);

    // 0xA5, good stop, consumer always ready
    rdy_a = 1'b1;
    exp_q.push_back({2'b00, 8'hA5});
    a0 = acc_a; v0 = vcyc_a;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1, -1);
    check_eq("a5_busy_after_stop", busy_a, 0);
    idle(64);
    check_eq("a5_accepts", acc_a - a0, 1);
    check_eq("a5_valid_cycles", vcyc_a - v0, 1);
    check_eq("a5_data", data_a, 8'hA5);
    check_eq("a5_ferr", ferr_a, 0);
    check_eq("a5_perr", perr_a, 0);

    // 5-tick glitch on the start bit
    busy_seen_a = 0; v0 = vcyc_a;
    rx_a = 1'b0;
    idle(20);
    rx_a = 1'b1;
    idle(80);
    check_eq("glitch_busy_seen", busy_seen_a, 1);
    check_eq("glitch_busy_end", busy_a, 0);
    check_eq("glitch_state", st_a, 0);
    check_eq("glitch_no_valid", vcyc_a - v0, 0);

    // framing error, then a held-low line
    exp_q.push_back({2'b01, 8'h3C});
    a0 = acc_a;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, -1, -1);
    rx_a = 1'b1;
    idle(128);
    check_eq("ferr_accepts", acc_a - a0, 1);
    check_eq("ferr_flag", ferr_a, 1);
    check_eq("ferr_data", data_a, 8'h3C);
    exp_q.push_back({2'b01, 8'h00});
    a0 = acc_a;
    rx_a = 1'b0;
    idle(40 * BIT_CLK);
    check_eq("break_one_frame", acc_a - a0, 1);
    check_eq("break_wait_state", st_a, 5);
    rx_a = 1'b1;
    idle(128);
    check_eq("break_no_more", acc_a - a0, 1);
    check_eq("break_idle", busy_a, 0);

    // even parity on 0x07 (three ones)
    rdy_b = 1'b1;
    b0 = acc_b;
    exp_qp.push_back({2'b00, 8'h07});
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, -1, -1);
    idle(64);
    check_eq("par_ok_perr", perr_b, 0);
    exp_qp.push_back({2'b10, 8'h07});
    send_frame(1'b1, 8'h07, 1'b0, 1'b1, -1, -1);
    idle(64);
    check_eq("par_bad_perr", perr_b, 1);
    check_eq("par_accepts", acc_b - b0, 2);

    // overrun: consumer stalled
    rdy_a = 1'b0;
    o0 = ovr_cnt_a;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, -1, -1);
    check_eq("ovr_first_valid", v_a, 1);
    check_eq("ovr_first_data", data_a, 8'h11);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1, -1, -1);
    check_eq("ovr_data_kept", data_a, 8'h11);
    check_eq("ovr_pulses", ovr_cnt_a - o0, 1);
    check_eq("ovr_still_valid", v_a, 1);
    exp_q.push_back({2'b00, 8'h11});
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    @(negedge clk);
    check_eq("ovr_drained", v_a, 0);

    // ready asserted exactly in the completion cycle of the second word
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, -1, -1);
    check_eq("swap_first_valid", v_a, 1);
    exp_q.push_back({2'b00, 8'h11});
    o0 = ovr_cnt_a;
    send_frame(1'b0, 8'h22, 1'b0, 1'b1, 36, -1);
    check_eq("swap_data", data_a, 8'h22);
    check_eq("swap_valid", v_a, 1);
    check_eq("swap_no_overrun", ovr_cnt_a - o0, 0);
    exp_q.push_back({2'b00, 8'h22});
    rdy_a = 1'b1;
    idle(2);

    // reset during data bit 4 of 0xFF, then 0x81
    a0 = acc_a;
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, -1, 4);
    check_eq("rst_mid_valid", v_a, 0);
    check_eq("rst_mid_busy", busy_a, 0);
    exp_q.push_back({2'b00, 8'h81});
    send_frame(1'b0, 8'h81, 1'b0, 1'b1, -1, -1);
    idle(64);
    check_eq("rst_mid_accepts", acc_a - a0, 1);
    check_eq("rst_mid_data", data_a, 8'h81);
    check_eq("rst_mid_ferr", ferr_a, 0);

    check_eq("exp_q_left", exp_q.size(), 0);
    check_eq("exp_qp_left", exp_qp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
